// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks: parity modes, transmitter
// state encoding and the default bit period.
package serial_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // 100 MHz system clock at 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Parity bit appended after the data bits for the given mode
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while clear is high so a bit starts on a clean count.
module baud_tick_gen
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("baud_tick_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] count_reg, count_next;

  assign tick = (count_reg == LAST);

  always_comb begin
    count_next = count_reg + CNT_W'(1);
    if (clear || tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. One byte per accepted tx_start_i/tx_ready_o handshake.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_o
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("serial_tx: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("serial_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("serial_tx: STOP_BITS must be 1 or 2");
  end

  tx_state_e  state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] idx_reg, idx_next;
  logic       par_reg, par_next;
  logic       tx_reg, tx_next;
  logic       ready_reg, ready_next;
  logic       done_reg, done_next;
  logic       bit_tick;
  logic       baud_clear;

  // Timer sits at zero while idle, so the start bit gets a full period
  assign baud_clear = (state_reg == ST_IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (bit_tick)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        tx_next    = 1'b1;
        ready_next = 1'b1;
        if (tx_start_i && ready_reg) begin
          shift_next = tx_data_i;
          par_next   = parity_bit(tx_data_i, PARITY);
          state_next = ST_START;
          tx_next    = 1'b0;
          ready_next = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_next = ST_DATA;
          idx_next   = 3'd0;
          tx_next    = shift_reg[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_next = shift_reg >> 1;
          idx_next   = idx_reg + 3'd1;
          tx_next    = shift_reg[1];
          if (idx_reg == 3'd7) begin
            idx_next = 3'd0;
            if (PARITY != PARITY_NONE) begin
              state_next = ST_PARITY;
              tx_next    = par_reg;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_next = ST_STOP;
          idx_next   = 3'd0;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_tick) begin
          // idx counts stop bits already completed
          if (idx_reg == 3'(STOP_BITS - 1)) begin
            state_next = ST_IDLE;
            ready_next = 1'b1;
            done_next  = 1'b1;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      idx_reg   <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  assign tx_o       = tx_reg;
  assign tx_ready_o = ready_reg;
  assign tx_done_o  = done_reg;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four instances (no parity, even, odd, two stop bits)
// checked every cycle against a frame-level model, plus directed literal checks.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int N  = 4;
  localparam int NI = 4;
  localparam int CW = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] data = 8'h00;
  logic [NI-1:0] tx_v, rdy_v, done_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic int par_of(input int i);
    return (i == 1) ? PARITY_EVEN : (i == 2) ? PARITY_ODD : PARITY_NONE;
  endfunction

  function automatic int stop_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    serial_tx #(
      .CLKS_PER_BIT(N),
      .PARITY      (par_of(gi)),
      .STOP_BITS   (stop_of(gi))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tx_start_i(start),
      .tx_data_i (data),
      .tx_ready_o(rdy_v[gi]),
      .tx_done_o (done_v[gi]),
      .tx_o      (tx_v[gi])
    );
  end

  // Frame-level model: on acceptance build the whole bit list, then the
  // line level is simply bit[elapsed / N] until elapsed reaches len * N.
  logic [NI-1:0] m_busy = '0;
  logic [NI-1:0] m_tx   = '1;
  logic [NI-1:0] m_rdy  = '1;
  logic [NI-1:0] m_done = '0;
  int   m_pos [NI];
  int   m_len [NI];
  logic m_bits [NI][12];

  always @(posedge clk) begin
    int ones;
    int nb;
    for (int i = 0; i < NI; i++) begin
      m_done[i] = 1'b0;
      if (rst) begin
        m_busy[i] = 1'b0;
      end else if (m_busy[i]) begin
        m_pos[i]++;
        if (m_pos[i] == m_len[i] * N) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end else if (start) begin
        ones = 0;
        nb = 0;
        m_bits[i][nb] = 1'b0; nb++;
        for (int j = 0; j < 8; j++) begin
          m_bits[i][nb] = data[j]; nb++;
          if (data[j]) ones++;
        end
        if (par_of(i) == PARITY_EVEN) begin
          m_bits[i][nb] = (ones % 2) == 1; nb++;
        end else if (par_of(i) == PARITY_ODD) begin
          m_bits[i][nb] = (ones % 2) == 0; nb++;
        end
        for (int s = 0; s < stop_of(i); s++) begin
          m_bits[i][nb] = 1'b1; nb++;
        end
        m_len[i]  = nb;
        m_pos[i]  = 0;
        m_busy[i] = 1'b1;
      end
      m_rdy[i] = !m_busy[i];
      m_tx[i]  = m_busy[i] ? m_bits[i][m_pos[i] / N] : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every instance against the model
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("tx[%0d]", i),    32'(tx_v[i]),   32'(m_tx[i]));
      chk($sformatf("ready[%0d]", i), 32'(rdy_v[i]),  32'(m_rdy[i]));
      chk($sformatf("done[%0d]", i),  32'(done_v[i]), 32'(m_done[i]));
    end
  endtask

  logic cap_tx   [NI][CW];
  logic cap_rdy  [NI][CW];
  logic cap_done [NI][CW];

  // Request a byte and record w cycles; k = 0 is the cycle after acceptance
  task automatic run_frame(input logic [7:0] d, input bit hold, input int w,
                           input int swap_k, input logic [7:0] d2);
    data  = d;
    start = 1'b1;
    for (int k = 0; k < w; k++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        cap_tx[i][k]   = tx_v[i];
        cap_rdy[i][k]  = rdy_v[i];
        cap_done[i][k] = done_v[i];
      end
      if (!hold && k == 0) start = 1'b0;
      if (k == swap_k) data = d2;
    end
    start = 1'b0;
    $display("frame 0x%02h hold=%0d captured %0d cycles", d, hold, w);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (!(&rdy_v) && c < 200) begin
      tick();
      c++;
    end
    chk("idle_timeout", 32'(&rdy_v), 32'd1);
  endtask

  function automatic int low_len(input int i, input int w);
    int n;
    n = 0;
    for (int k = 0; k < w; k++) if (!cap_rdy[i][k]) n++;
    return n;
  endfunction

  function automatic int done_cnt(input int i, input int w);
    int n;
    n = 0;
    for (int k = 0; k < w; k++) if (cap_done[i][k]) n++;
    return n;
  endfunction

  function automatic logic [7:0] decode(input int i, input int base);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = cap_tx[i][base + N * (1 + j) + 2];
    return b;
  endfunction

  initial begin
    logic [9:0] pat55;
    logic [3:0] seg;
    int dcnt;
    int ones_stop;

    // Reset held for three cycles
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_tx", 32'(tx_v), 32'hF);
      chk("rst_ready", 32'(rdy_v), 32'hF);
      chk("rst_done", 32'(done_v), 32'h0);
    end
    rst = 1'b0;
    tick();

    // 0x55, frame lengths and done placement
    run_frame(8'h55, 1'b0, 50, -1, 8'h00);
    pat55 = 10'b10_1010_1010;
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < N; c++) seg[c] = cap_tx[0][N * j + c];
      chk($sformatf("x55_bit%0d", j), 32'(seg), 32'({4{pat55[j]}}));
    end
    chk("x55_len0", 32'(low_len(0, 50)), 32'd40);
    chk("x55_len1", 32'(low_len(1, 50)), 32'd44);
    chk("x55_len3", 32'(low_len(3, 50)), 32'd44);
    chk("x55_done_cnt", 32'(done_cnt(0, 50)), 32'd1);
    chk("x55_done_at_rise", 32'({cap_rdy[0][39], cap_rdy[0][40], cap_done[0][40]}), 32'b011);
    wait_idle();

    // Command-parser handshake: one frame, no second start bit
    run_frame(8'h41, 1'b0, 60, -1, 8'h00);
    chk("x41_data", 32'(decode(0, 0)), 32'h41);
    chk("x41_data_par", 32'(decode(1, 0)), 32'h41);
    dcnt = 0;
    for (int k = 40; k < 60; k++) if (!cap_tx[0][k]) dcnt++;
    chk("x41_no_restart", 32'(dcnt), 32'd0);
    chk("x41_done_cnt", 32'(done_cnt(0, 60)), 32'd1);
    wait_idle();

    // Back-to-back with data changed during frame 1
    run_frame(8'h31, 1'b1, 82, 10, 8'h30);
    chk("b2b_f1", 32'(decode(0, 0)), 32'h31);
    chk("b2b_gap", 32'({cap_tx[0][40], cap_rdy[0][40], cap_tx[0][41], cap_rdy[0][41]}), 32'b1100);
    chk("b2b_f2", 32'(decode(0, 41)), 32'h30);
    chk("b2b_f2_par", 32'(decode(1, 45)), 32'h30);
    wait_idle();

    // Parity and two stop bits on 0x07
    run_frame(8'h07, 1'b0, 50, -1, 8'h00);
    chk("par_even_bit", 32'(cap_tx[1][38]), 32'd1);
    chk("par_odd_bit", 32'(cap_tx[2][38]), 32'd0);
    chk("par_even_len", 32'(low_len(1, 50)), 32'd44);
    ones_stop = 0;
    for (int k = 36; k < 44; k++) if (cap_tx[3][k]) ones_stop++;
    chk("stop2_high", 32'(ones_stop), 32'd8);
    chk("stop2_len", 32'(low_len(3, 50)), 32'd44);
    wait_idle();

    // Reset during data bit 3
    run_frame(8'hA5, 1'b0, 18, -1, 8'h00);
    rst = 1'b1;
    tick();
    chk("abort_tx", 32'(tx_v), 32'hF);
    chk("abort_ready", 32'(rdy_v), 32'hF);
    rst = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (|done_v) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    $display("mid-frame reset applied");
    run_frame(8'h0F, 1'b0, 50, -1, 8'h00);
    chk("after_abort_data", 32'(decode(0, 0)), 32'h0F);
    chk("after_abort_data3", 32'(decode(3, 0)), 32'h0F);
    chk("after_abort_len", 32'(low_len(0, 50)), 32'd40);
    wait_idle();

    // Random traffic, occasional resets
    for (int c = 0; c < 2500; c++) begin
      data  = 8'($urandom);
      start = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    $display("random phase complete");
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- UART-style serial transmitter. It is the responder on the byte-transmit handshake that the command parser drives (tx_start / tx_data / tx_ready).
- It serializes one byte per accepted request onto the board TX line toward the host: start bit, 8 data bits LSB first, optional parity, stop bit(s).
- It reports availability on a registered ready flag and pulses a done strobe at the end of each frame.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_start_i  in  1  transmit request; level-sensitive.
- tx_data_i  in  8  byte to send; sampled only at acceptance.
- tx_ready_o  out  1  1 = idle, can accept a request.
- tx_done_o  out  1  one-cycle pulse when a frame's last stop bit completes.
- tx_o  out  1  serial line; idle level 1.

Behaviour:
- Reset: one clock and reset; rst is synchronous and active-high. While rst = 1 at an edge: tx_o = 1, tx_ready_o = 1, tx_done_o = 0, state IDLE, counters 0.
- Reset mid-frame: the frame is aborted. The next edge gives tx_o = 1 and tx_ready_o = 1; no tx_done_o pulse.
- All outputs are registered.
- Acceptance: at a rising edge where tx_start_i = 1 and tx_ready_o = 1:
  - latch tx_data_i into the shift register;
  - compute the parity bit from the latched byte;
  - go to START; tx_o <= 0; tx_ready_o <= 0; baud count <= 0.
- tx_start_i with tx_ready_o = 0 is ignored (no queueing).
- tx_data_i changes after acceptance do not affect the frame.
- Bit timing: every bit holds tx_o for exactly CLKS_PER_BIT clocks.
  - The baud counter is $clog2(CLKS_PER_BIT) bits wide.
  - It counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit-end tick.
- States:
  - IDLE: tx_o = 1.
  - START: tx_o = 0; at bit end -> DATA with bit index 0.
  - DATA: tx_o = shift[0]; at bit end, shift right and increment the 3-bit index. After index 7: -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: tx_o = ^byte for even, ~^byte for odd; at bit end -> STOP.
  - STOP: tx_o = 1 for STOP_BITS bit times. At the final bit end -> IDLE with tx_ready_o <= 1 and tx_done_o <= 1 for that one cycle.
- Frame length: acceptance edge to tx_ready_o re-high = (1 + 8 + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT clocks.
- Back-to-back requests: if tx_start_i is still 1 in the cycle tx_ready_o returns high, the next frame is accepted at the following edge. tx_o stays 1 for exactly one extra clock between frames.
- Command-parser handshake: the requester holds tx_start_i until it sees tx_ready_o = 0, then drops it. This produces exactly one frame.
- Illegal parameters: CLKS_PER_BIT < 2, PARITY > 2 or STOP_BITS not in {1, 2} stop elaboration with an error.

Decomposition:
- Shared package serial_pkg:
  - parity encodings PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2;
  - tx state encoding IDLE, START, DATA, PARITY, STOP;
  - default CLKS_PER_BIT constant.
- Sub-module baud_tick_gen:
  - parameter CLKS_PER_BIT; inputs clk, rst, clear;
  - output tick = 1 on the last cycle of each bit period.
  - Reused by the future serial receiver.

Test Plan (CLKS_PER_BIT = 4 unless stated):
1. Reset: hold rst = 1 for 3 cycles -> tx_o = 1, tx_ready_o = 1, tx_done_o = 0 on every cycle.
2. Send 0x55, PARITY = 0, STOP_BITS = 1:
   - tx_o is 0,1,0,1,0,1,0,1,0,1, each held 4 clocks;
   - tx_ready_o is low for exactly 40 clocks;
   - tx_done_o pulses once, in the cycle tx_ready_o rises.
3. Command-parser handshake: assert tx_start_i with 0x41, drop it the cycle after tx_ready_o falls -> exactly one frame with data bits 1,0,0,0,0,0,1,0 and no second start bit.
4. tx_start_i held high with data 0x31, then 0x30 presented during frame 1:
   - frame 1 carries 0x31, frame 2 carries 0x30;
   - exactly one idle-high clock between frames.
5. Parity on 0x07:
   - PARITY = 2 (even) -> parity bit 1, frame 44 clocks;
   - PARITY = 1 (odd) -> parity bit 0;
   - STOP_BITS = 2 with PARITY = 0 -> 8 high clocks of stop, frame 44 clocks.
6. Reset mid-frame: assert rst during data bit 3 -> next edge tx_o = 1, tx_ready_o = 1; tx_done_o never pulses; a new 0x0F request afterwards sends a correct full frame.
